// File: rtl/traffic_sensor_conditioner.sv
// ============================================================================
// Module      : traffic_sensor_conditioner
// Description : Synchronizes, debounces and latches the three vehicle-loop
//               requests feeding the 3-street traffic light controller.
//               Optional stuck-loop detection via macro TSC_STUCK_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package light_package;
    typedef enum logic [1:0] {
        red    = 2'd0,
        yellow = 2'd1,
        green  = 2'd2
    } colors;
endpackage

module traffic_sensor_conditioner
    import light_package::*;
#(
    parameter int DEBOUNCE    = 3,
    parameter int STUCK_LIMIT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_ew_str,
    input  logic       raw_ew_left,
    input  logic       raw_ns,
    input  colors      ew_str_light,
    input  colors      ew_left_light,
    input  colors      ns_light,
    output logic       ew_str_sensor,
    output logic       ew_left_sensor,
    output logic       ns_sensor,
    output logic [2:0] stuck_fault
);

    localparam logic [3:0] C_DEB_LAST = 4'(DEBOUNCE - 1);

    logic [2:0] raw_w;
    logic [2:0] green_w;
    logic [2:0] sensor_w;

    assign raw_w   = {raw_ew_str, raw_ew_left, raw_ns};
    assign green_w = {ew_str_light == green, ew_left_light == green, ns_light == green};

    assign ew_str_sensor  = sensor_w[2];
    assign ew_left_sensor = sensor_w[1];
    assign ns_sensor      = sensor_w[0];

    for (genvar i = 0; i < 3; i++) begin : g_lane
        logic       sync1_q, sync1_d;
        logic       sync2_q, sync2_d;
        logic       deb_q, deb_d;
        logic [3:0] dcnt_q, dcnt_d;
        logic       call_q, call_d;
        logic       rise_w;

        always_comb begin
            sync1_d = raw_w[i];
            sync2_d = sync1_q;
            deb_d   = deb_q;
            dcnt_d  = 4'd0;
            rise_w  = 1'b0;
            if (sync2_q != deb_q) begin
                if (dcnt_q == C_DEB_LAST) begin
                    deb_d  = ~deb_q;
                    rise_w = ~deb_q;
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end
            // Green wins over a simultaneous debounced rise.
            if (green_w[i]) begin
                call_d = 1'b0;
            end else begin
                call_d = call_q | rise_w;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                deb_q   <= 1'b0;
                dcnt_q  <= 4'd0;
                call_q  <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                deb_q   <= deb_d;
                dcnt_q  <= dcnt_d;
                call_q  <= call_d;
            end
        end

`ifdef TSC_STUCK_DETECT_EN
        localparam logic [7:0] C_STUCK_LAST = 8'(STUCK_LIMIT - 1);

        logic [7:0] scnt_q, scnt_d;
        logic       fault_q, fault_d;
        logic       green_q, green_d;

        always_comb begin
            scnt_d  = 8'd0;
            green_d = green_w[i];
            if (deb_q) begin
                scnt_d = (scnt_q == 8'hFF) ? scnt_q : scnt_q + 8'd1;
            end
            fault_d = deb_q & (fault_q | (scnt_q >= C_STUCK_LAST));
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                scnt_q  <= 8'd0;
                fault_q <= 1'b0;
                green_q <= 1'b0;
            end else begin
                scnt_q  <= scnt_d;
                fault_q <= fault_d;
                green_q <= green_d;
            end
        end

        // Recall mode: request whenever not green, registered light keeps
        // the output free of input-to-output paths.
        assign sensor_w[i]    = fault_q ? ~green_q : (deb_q | call_q);
        assign stuck_fault[i] = fault_q;
`else
        assign sensor_w[i]    = deb_q | call_q;
        assign stuck_fault[i] = 1'b0;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_traffic_sensor_conditioner.sv
// ============================================================================
// Module      : tb_traffic_sensor_conditioner
// Description : Directed plus randomized bench against a history-window model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_sensor_conditioner;
    import light_package::*;

    localparam int DEB = 3;
    localparam int LIM = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_ew_str, raw_ew_left, raw_ns;
    colors      ew_str_light, ew_left_light, ns_light;
    logic       ew_str_sensor, ew_left_sensor, ns_sensor;
    logic [2:0] stuck_fault;

    traffic_sensor_conditioner #(.DEBOUNCE(DEB), .STUCK_LIMIT(LIM)) dut (
        .clk            (clk),
        .reset          (reset),
        .raw_ew_str     (raw_ew_str),
        .raw_ew_left    (raw_ew_left),
        .raw_ns         (raw_ns),
        .ew_str_light   (ew_str_light),
        .ew_left_light  (ew_left_light),
        .ns_light       (ns_light),
        .ew_str_sensor  (ew_str_sensor),
        .ew_left_sensor (ew_left_sensor),
        .ns_sensor      (ns_sensor),
        .stuck_fault    (stuck_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: hist bit k holds the raw level sampled k edges ago.
    bit [31:0] hist  [3];
    bit        deb_m [3];
    bit        call_m[3];
    bit        flt_m [3];
    bit        grn_m [3];
    int        run_m [3];

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 3; l++) begin
            hist[l] = '0; deb_m[l] = 0; call_m[l] = 0;
            flt_m[l] = 0; grn_m[l] = 0; run_m[l] = 0;
        end
    endtask

    function automatic logic [2:0] exp_sensors();
        logic [2:0] s;
        for (int l = 0; l < 3; l++)
            s[l] = flt_m[l] ? !grn_m[l] : (deb_m[l] | call_m[l]);
        return s;
    endfunction

    function automatic logic [2:0] exp_faults();
        logic [2:0] f;
        for (int l = 0; l < 3; l++) f[l] = flt_m[l];
        return f;
    endfunction

    task automatic tick();
        logic [2:0] raws, grns;
        bit prev, tog, rise;
        @(posedge clk);
        raws = {raw_ew_str, raw_ew_left, raw_ns};
        grns = {ew_str_light == green, ew_left_light == green, ns_light == green};
        if (!reset) begin
            model_reset();
        end else begin
            for (int l = 0; l < 3; l++) begin
                prev    = deb_m[l];
                hist[l] = {hist[l][30:0], raws[l]};
                // Level seen by the filter on each of the last DEB edges.
                tog = 1;
                for (int k = 2; k <= DEB + 1; k++)
                    if (hist[l][k] == deb_m[l]) tog = 0;
                rise = 0;
                if (tog) begin
                    deb_m[l] = !deb_m[l];
                    rise     = deb_m[l];
                end
                call_m[l] = grns[l] ? 1'b0 : (call_m[l] | rise);
`ifdef TSC_STUCK_DETECT_EN
                run_m[l] = prev ? ((run_m[l] < 255) ? run_m[l] + 1 : 255) : 0;
                flt_m[l] = prev && (flt_m[l] || run_m[l] >= LIM);
                grn_m[l] = grns[l];
`endif
            end
        end
        #1;
        chk("model_sensors", {ew_str_sensor, ew_left_sensor, ns_sensor}, exp_sensors());
        chk("model_faults", stuck_fault, exp_faults());
    endtask

    task automatic clear_all();
        raw_ew_str = 0; raw_ew_left = 0; raw_ns = 0;
        ew_str_light = green; ew_left_light = green; ns_light = green;
        repeat (10) tick();
        ew_str_light = red; ew_left_light = red; ns_light = red;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        raw_ew_str = 0; raw_ew_left = 0; raw_ns = 0;
        ew_str_light = red; ew_left_light = red; ns_light = red;
        model_reset();
        repeat (2) tick();
        chk("reset_sensors", {ew_str_sensor, ew_left_sensor, ns_sensor}, 3'b000);
        chk("reset_fault", stuck_fault, 3'b000);
        reset = 1'b1;
        repeat (2) tick();

        // Glitch rejection
        clear_all();
        raw_ns = 1; repeat (2) tick();
        raw_ns = 0; repeat (8) tick();
        chk("glitch_ns", {2'b00, ns_sensor}, 3'b000);

        // Qualification latency
        clear_all();
        raw_ew_left = 1;
        repeat (4) tick();
        chk("latency_edge4", {1'b0, ew_left_sensor, 1'b0}, 3'b000);
        tick();
        chk("latency_edge5", {1'b0, ew_left_sensor, 1'b0}, 3'b010);

        // Call memory
        clear_all();
        raw_ns = 1; repeat (6) tick();
        raw_ns = 0; repeat (10) tick();
        chk("call_held", {2'b00, ns_sensor}, 3'b001);
        ns_light = green; tick();
        chk("call_cleared", {2'b00, ns_sensor}, 3'b000);

        // Green passthrough
        clear_all();
        ew_str_light = green;
        raw_ew_str = 1; repeat (10) tick();
        chk("green_high", {ew_str_sensor, 2'b00}, 3'b100);
        raw_ew_str = 0; repeat (4) tick();
        chk("green_fall4", {ew_str_sensor, 2'b00}, 3'b100);
        tick();
        chk("green_fall5", {ew_str_sensor, 2'b00}, 3'b000);

        // Asynchronous reset with calls latched
        clear_all();
        raw_ew_str = 1; raw_ew_left = 1; raw_ns = 1;
        repeat (6) tick();
        raw_ew_str = 0; raw_ew_left = 0; raw_ns = 0;
        repeat (8) tick();
        chk("calls_latched", {ew_str_sensor, ew_left_sensor, ns_sensor}, 3'b111);
        #2 reset = 1'b0;
        #1;
        chk("async_reset", {ew_str_sensor, ew_left_sensor, ns_sensor}, 3'b000);
        model_reset();
        repeat (2) tick();
        #2 reset = 1'b1;
        repeat (10) tick();
        chk("post_reset", {ew_str_sensor, ew_left_sensor, ns_sensor}, 3'b000);

`ifdef TSC_STUCK_DETECT_EN
        // Stuck loop and recall mode
        clear_all();
        raw_ew_str = 1;
        repeat (80) tick();
        chk("stuck_set", stuck_fault, 3'b100);
        chk("recall_red", {ew_str_sensor, 2'b00}, 3'b100);
        ew_str_light = green; repeat (2) tick();
        chk("recall_green", {ew_str_sensor, 2'b00}, 3'b000);
        raw_ew_str = 0; repeat (8) tick();
        chk("stuck_clear", stuck_fault, 3'b000);
`endif

        // Randomized traffic against the model
        clear_all();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) raw_ew_str  = ~raw_ew_str;
            if ($urandom_range(0, 4) == 0) raw_ew_left = ~raw_ew_left;
            if ($urandom_range(0, 4) == 0) raw_ns      = ~raw_ns;
            if ($urandom_range(0, 9) == 0) ew_str_light  = colors'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) ew_left_light = colors'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) ns_light      = colors'($urandom_range(0, 2));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
